// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch stage: opcode and ALU control
// encodings, pipeline tag types, and the opcode decode helper.
package alu_pkg;

    // Decoded opcode encodings arriving from the decode stage
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_MUL = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_MOV = 6'd14;
    localparam logic [5:0] OP_BEQ = 6'd30;

    // Control codes understood by the registered ALU
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;

    // What an in-flight op does when it reaches the end of the pipe
    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        BR   = 2'd2
    } kind_e;

    // Tag that travels alongside each pipeline slot
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        kind_e      kind;
    } tag_t;

    // Result of decoding one opcode
    typedef struct packed {
        logic       legal;
        logic [3:0] ctrl;
        kind_e      kind;
        logic       zero_op2;
    } dec_t;

    // Map an opcode onto its ALU control code and writeback kind.
    // MOV is an OR against a zero second operand; BEQ is a subtract
    // whose result is only tested for zero.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.legal    = 1'b1;
        d.ctrl     = ALU_ADD;
        d.kind     = ALU;
        d.zero_op2 = 1'b0;
        case (op)
            OP_ADD: d.ctrl = ALU_ADD;
            OP_SUB: d.ctrl = ALU_SUB;
            OP_MUL: d.ctrl = ALU_MUL;
            OP_AND: d.ctrl = ALU_AND;
            OP_OR:  d.ctrl = ALU_OR;
            OP_MOV: begin
                d.ctrl     = ALU_OR;
                d.zero_op2 = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl = ALU_SUB;
                d.kind = BR;
            end
            default: begin
                d.legal = 1'b0;
                d.kind  = NONE;
            end
        endcase
        return d;
    endfunction

    // True when a register index depends on the result of a tagged producer.
    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic producer_match(input tag_t t, input logic [4:0] idx);
        return t.valid && (t.kind == ALU) && (idx != 5'd0) && (t.rd == idx);
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Bundle of the decode-side handshake, ALU operand/result bus and the
// writeback/branch outputs of the dispatch stage.
// master: decode + ALU + register-file side; slave: the dispatch stage.
interface alu_dispatch_if #(parameter int W = 32);

    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_op;
    logic [4:0]   in_rd;
    logic [4:0]   in_rs;
    logic [4:0]   in_rt;
    logic [W-1:0] in_rs_val;
    logic [W-1:0] in_rt_val;

    logic [3:0]   alu_control;
    logic [W-1:0] alu_oper1;
    logic [W-1:0] alu_oper2;
    logic [W-1:0] alu_result;

    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic         br_valid;
    logic         br_taken;
    logic         err;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_rs_val, in_rt_val,
        output alu_result,
        input  in_ready, alu_control, alu_oper1, alu_oper2,
        input  wb_valid, wb_rd, wb_data, br_valid, br_taken, err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_rs_val, in_rt_val,
        input  alu_result,
        output in_ready, alu_control, alu_oper1, alu_oper2,
        output wb_valid, wb_rd, wb_data, br_valid, br_taken, err
    );

endinterface

// File: rtl/alu_hazard.sv
// Read-after-write hazard unit for the ALU dispatch stage: compares source
// indices against in-flight producers and decides stall and operand bypass.
// Optional feature macro: ALU_DISPATCH_FWD_EN (operand forwarding).
module alu_hazard
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  tag_t         i_s1,
    input  tag_t         i_s2,
    input  logic         i_wb_valid,
    input  logic [4:0]   i_wb_rd,
    input  logic [4:0]   i_rs,
    input  logic [4:0]   i_rt,
    input  logic [W-1:0] i_rs_val,
    input  logic [W-1:0] i_rt_val,
    input  logic [W-1:0] i_alu_result,
    input  logic [W-1:0] i_wb_data,
    output logic         o_stall,
    output logic [W-1:0] o_rs_val,
    output logic [W-1:0] o_rt_val
);

    logic w_s1_rs;
    logic w_s1_rt;
    logic w_s2_rs;
    logic w_s2_rt;

    assign w_s1_rs = producer_match(i_s1, i_rs);
    assign w_s1_rt = producer_match(i_s1, i_rt);
    assign w_s2_rs = producer_match(i_s2, i_rs);
    assign w_s2_rt = producer_match(i_s2, i_rt);

`ifdef ALU_DISPATCH_FWD_EN

    logic w_wb_rs;
    logic w_wb_rt;

    assign w_wb_rs = i_wb_valid && (i_rs != 5'd0) && (i_wb_rd == i_rs);
    assign w_wb_rt = i_wb_valid && (i_rt != 5'd0) && (i_wb_rd == i_rt);

    // Only the S1 producer forces a stall: its result does not exist yet.
    // The younger S2 producer outranks the older writeback value.
    always_comb begin
        o_stall  = w_s1_rs | w_s1_rt;
        o_rs_val = i_rs_val;
        o_rt_val = i_rt_val;
        if (w_s2_rs) begin
            o_rs_val = i_alu_result;
        end else if (w_wb_rs) begin
            o_rs_val = i_wb_data;
        end
        if (w_s2_rt) begin
            o_rt_val = i_alu_result;
        end else if (w_wb_rt) begin
            o_rt_val = i_wb_data;
        end
    end

`else

    // Bypass data is not needed without forwarding; folded here so the
    // ports stay identical between builds.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_wb_valid, i_wb_rd, i_alu_result, i_wb_data};

    // Any dependency on a producer still in S1 or S2 holds the op back
    // until the register file can supply the value.
    always_comb begin
        o_stall  = w_s1_rs | w_s1_rt | w_s2_rs | w_s2_rt;
        o_rs_val = i_rs_val;
        o_rt_val = i_rt_val;
    end

`endif

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage in front of the registered ALU: accepts decoded instructions,
// drives registered ALU operands, and turns the ALU result into a
// register-file writeback or a branch outcome two cycles after accept.
// Optional feature macro: ALU_DISPATCH_FWD_EN (operand forwarding, see alu_hazard).
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_dispatch_if.slave  bus
);

    dec_t         w_dec;
    tag_t         w_issue_tag;
    logic         w_stall;
    logic         w_accept;
    logic         w_issue;
    logic [W-1:0] w_rs_val;
    logic [W-1:0] w_rt_val;
    logic         w_result_zero;
    logic         w_s2_alu;
    logic         w_s2_br;

    tag_t         r_s1;
    tag_t         r_s2;
    logic [3:0]   r_alu_control;
    logic [W-1:0] r_alu_oper1;
    logic [W-1:0] r_alu_oper2;
    logic         r_wb_valid;
    logic [4:0]   r_wb_rd;
    logic [W-1:0] r_wb_data;
    logic         r_br_valid;
    logic         r_br_taken;
    logic         r_err;

    assign w_dec = decode_op(bus.in_op);

    alu_hazard #(.W(W)) u_hazard (
        .i_s1         (r_s1),
        .i_s2         (r_s2),
        .i_wb_valid   (r_wb_valid),
        .i_wb_rd      (r_wb_rd),
        .i_rs         (bus.in_rs),
        .i_rt         (bus.in_rt),
        .i_rs_val     (bus.in_rs_val),
        .i_rt_val     (bus.in_rt_val),
        .i_alu_result (bus.alu_result),
        .i_wb_data    (r_wb_data),
        .o_stall      (w_stall),
        .o_rs_val     (w_rs_val),
        .o_rt_val     (w_rt_val)
    );

    assign bus.in_ready = ~w_stall;
    assign w_accept     = bus.in_valid & ~w_stall;
    assign w_issue      = w_accept & w_dec.legal;

    assign w_s2_alu      = r_s2.valid && (r_s2.kind == ALU);
    assign w_s2_br       = r_s2.valid && (r_s2.kind == BR);
    assign w_result_zero = (bus.alu_result == '0);

    // Build the S1 tag for this cycle; illegal or absent ops become a bubble
    always_comb begin
        w_issue_tag.valid = w_issue;
        w_issue_tag.rd    = bus.in_rd;
        w_issue_tag.kind  = w_issue ? w_dec.kind : NONE;
    end

    // Register the ALU inputs and S1 tag for each issued op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1          <= '{valid: 1'b0, rd: 5'd0, kind: NONE};
            r_alu_control <= 4'd0;
            r_alu_oper1   <= '0;
            r_alu_oper2   <= '0;
        end else begin
            r_s1 <= w_issue_tag;
            if (w_issue) begin
                r_alu_control <= w_dec.ctrl;
                r_alu_oper1   <= w_rs_val;
                r_alu_oper2   <= w_dec.zero_op2 ? '0 : w_rt_val;
            end
        end
    end

    // Advance the tag alongside the cycle in which the ALU result is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2 <= '{valid: 1'b0, rd: 5'd0, kind: NONE};
        end else begin
            r_s2 <= r_s1;
        end
    end

    // Capture the ALU result as a writeback or branch outcome; rd 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
            r_br_valid <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_wb_valid <= w_s2_alu && (r_s2.rd != 5'd0);
            r_br_valid <= w_s2_br;
            r_br_taken <= w_s2_br && w_result_zero;
            if (w_s2_alu) begin
                r_wb_rd   <= r_s2.rd;
                r_wb_data <= bus.alu_result;
            end
        end
    end

    // Remember any accepted illegal opcode until the next reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_dec.legal) begin
            r_err <= 1'b1;
        end
    end

    assign bus.alu_control = r_alu_control;
    assign bus.alu_oper1   = r_alu_oper1;
    assign bus.alu_oper2   = r_alu_oper2;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.br_valid    = r_br_valid;
    assign bus.br_taken    = r_br_taken;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed testbench for alu_dispatch with a registered ALU model.
// Expected stall counts and stale operand values depend on ALU_DISPATCH_FWD_EN.
module tb_alu_dispatch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef ALU_DISPATCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    alu_dispatch_if #(.W(32)) bus ();

    alu_dispatch #(.W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Registered ALU model: result appears one edge after the operands
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_result <= '0;
        end else begin
            case (bus.alu_control)
                4'd0:    bus.alu_result <= bus.alu_oper1 + bus.alu_oper2;
                4'd1:    bus.alu_result <= bus.alu_oper1 - bus.alu_oper2;
                4'd2:    bus.alu_result <= bus.alu_oper1 * bus.alu_oper2;
                4'd3:    bus.alu_result <= bus.alu_oper1 & bus.alu_oper2;
                4'd4:    bus.alu_result <= bus.alu_oper1 | bus.alu_oper2;
                default: bus.alu_result <= '0;
            endcase
        end
    end

    // Present one instruction (called at a negedge), wait for acceptance with a
    // bounded stall count, and return at the negedge right after the accepting edge
    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] rsv, input logic [31:0] rtv,
                        output int stalls);
        stalls        = 0;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rs_val = rsv;
        bus.in_rt_val = rtv;
        #1;
        while (!bus.in_ready && stalls < 10) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_wb_valid got=%0h exp=0", bus.wb_valid); end
        checks++; if (bus.alu_control !== 4'd0) begin errors++; $display("[TB] FAIL rst_alu_control got=%0h exp=0", bus.alu_control); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got=%0h exp=0", bus.err); end
        checks++; if (bus.br_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_br_valid got=%0h exp=0", bus.br_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got=%0h exp=1", bus.in_ready); end
        checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_wb_data got=%0h exp=0", bus.wb_data); end
    endtask

    task automatic test_add();
        int st;
        send(6'd0, 5'd3, 5'd5, 5'd7, 32'd5, 32'd7, st);
        checks++; if (st !== 0) begin errors++; $display("[TB] FAIL add_stalls got=%0d exp=0", st); end
        checks++; if (bus.alu_control !== 4'd0) begin errors++; $display("[TB] FAIL add_ctrl got=%0h exp=0", bus.alu_control); end
        checks++; if (bus.alu_oper1 !== 32'd5 || bus.alu_oper2 !== 32'd7) begin errors++; $display("[TB] FAIL add_opers got=%0h,%0h exp=5,7", bus.alu_oper1, bus.alu_oper2); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_wb_early got=%0h exp=0", bus.wb_valid); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3) begin errors++; $display("[TB] FAIL add_wb got=%0h rd=%0d exp=1 rd=3", bus.wb_valid, bus.wb_rd); end
        checks++; if (bus.wb_data !== 32'd12) begin errors++; $display("[TB] FAIL add_wb_data got=%0h exp=c", bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_wb_pulse got=%0h exp=0", bus.wb_valid); end
    endtask

    task automatic test_mul_beq();
        int st;
        send(6'd2, 5'd6, 5'd8, 5'd9, 32'h0001_0000, 32'h0001_0000, st);
        checks++; if (bus.alu_control !== 4'd2) begin errors++; $display("[TB] FAIL mul_ctrl got=%0h exp=2", bus.alu_control); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd0) begin errors++; $display("[TB] FAIL mul_wb got=%0h data=%0h exp=1 data=0", bus.wb_valid, bus.wb_data); end
        send(6'd30, 5'd15, 5'd10, 5'd11, 32'd9, 32'd9, st);
        checks++; if (bus.alu_control !== 4'd1) begin errors++; $display("[TB] FAIL beq_ctrl got=%0h exp=1", bus.alu_control); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1) begin errors++; $display("[TB] FAIL beq_eq got=%0h taken=%0h exp=1 taken=1", bus.br_valid, bus.br_taken); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_no_wb got=%0h exp=0", bus.wb_valid); end
        @(negedge clk);
        checks++; if (bus.br_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_pulse got=%0h exp=0", bus.br_valid); end
        send(6'd30, 5'd15, 5'd10, 5'd11, 32'd9, 32'd8, st);
        @(negedge clk); @(negedge clk);
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b0) begin errors++; $display("[TB] FAIL beq_ne got=%0h taken=%0h exp=1 taken=0", bus.br_valid, bus.br_taken); end
    endtask

    task automatic test_back_to_back();
        int st1, st2, st3;
        send(6'd0, 5'd12, 5'd20, 5'd21, 32'd1, 32'd1, st1);
        send(6'd3, 5'd13, 5'd22, 5'd23, 32'hF0F0, 32'hFF00, st2);
        send(6'd4, 5'd14, 5'd24, 5'd25, 32'h0F, 32'hF0, st3);
        checks++; if (st1 + st2 + st3 !== 0) begin errors++; $display("[TB] FAIL b2b_stalls got=%0d exp=0", st1 + st2 + st3); end
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd12 || bus.wb_data !== 32'd2) begin errors++; $display("[TB] FAIL b2b_add rd=%0d data=%0h exp rd=12 data=2", bus.wb_rd, bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd13 || bus.wb_data !== 32'hF000) begin errors++; $display("[TB] FAIL b2b_and rd=%0d data=%0h exp rd=13 data=f000", bus.wb_rd, bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd14 || bus.wb_data !== 32'hFF) begin errors++; $display("[TB] FAIL b2b_or rd=%0d data=%0h exp rd=14 data=ff", bus.wb_rd, bus.wb_data); end
    endtask

    task automatic test_hazard();
        int st;
        // dependent op directly behind its producer
        send(6'd0, 5'd1, 5'd20, 5'd21, 32'd1, 32'd2, st);
        send(6'd0, 5'd2, 5'd1, 5'd1, FWD ? 32'd0 : 32'd3, FWD ? 32'd0 : 32'd3, st);
        checks++; if (st !== (FWD ? 1 : 2)) begin errors++; $display("[TB] FAIL haz_adj_stalls got=%0d exp=%0d", st, FWD ? 1 : 2); end
        checks++; if (bus.alu_oper1 !== 32'd3 || bus.alu_oper2 !== 32'd3) begin errors++; $display("[TB] FAIL haz_adj_opers got=%0h,%0h exp=3,3", bus.alu_oper1, bus.alu_oper2); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd2 || bus.wb_data !== 32'd6) begin errors++; $display("[TB] FAIL haz_adj_wb rd=%0d data=%0h exp rd=2 data=6", bus.wb_rd, bus.wb_data); end
        // one independent op between producer and consumer
        send(6'd0, 5'd5, 5'd20, 5'd21, 32'd4, 32'd5, st);
        send(6'd0, 5'd6, 5'd22, 5'd23, 32'd1, 32'd1, st);
        send(6'd0, 5'd7, 5'd5, 5'd24, FWD ? 32'd0 : 32'd9, 32'd1, st);
        checks++; if (st !== (FWD ? 0 : 1)) begin errors++; $display("[TB] FAIL haz_gap_stalls got=%0d exp=%0d", st, FWD ? 0 : 1); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'd10) begin errors++; $display("[TB] FAIL haz_gap_wb rd=%0d data=%0h exp rd=7 data=a", bus.wb_rd, bus.wb_data); end
        // producer already at writeback when consumer arrives
        send(6'd0, 5'd8, 5'd20, 5'd21, 32'd7, 32'd8, st);
        send(6'd0, 5'd6, 5'd22, 5'd23, 32'd1, 32'd1, st);
        send(6'd0, 5'd6, 5'd22, 5'd23, 32'd1, 32'd1, st);
        send(6'd0, 5'd9, 5'd8, 5'd8, FWD ? 32'd0 : 32'd15, FWD ? 32'd0 : 32'd15, st);
        checks++; if (st !== 0) begin errors++; $display("[TB] FAIL haz_wb_stalls got=%0d exp=0", st); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd9 || bus.wb_data !== 32'd30) begin errors++; $display("[TB] FAIL haz_wb_wb rd=%0d data=%0h exp rd=9 data=1e", bus.wb_rd, bus.wb_data); end
    endtask

    task automatic test_illegal();
        int st;
        send(6'd17, 5'd8, 5'd25, 5'd26, 32'd1, 32'd1, st);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL ill_err got=%0h exp=1", bus.err); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0 || bus.br_valid !== 1'b0) begin errors++; $display("[TB] FAIL ill_bubble wb=%0h br=%0h exp=0,0", bus.wb_valid, bus.br_valid); end
        send(6'd0, 5'd9, 5'd25, 5'd26, 32'd2, 32'd3, st);
        checks++; if (st !== 0) begin errors++; $display("[TB] FAIL ill_next_stalls got=%0d exp=0", st); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd9 || bus.wb_data !== 32'd5) begin errors++; $display("[TB] FAIL ill_next_wb rd=%0d data=%0h exp rd=9 data=5", bus.wb_rd, bus.wb_data); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL ill_err_sticky got=%0h exp=1", bus.err); end
    endtask

    task automatic test_mov();
        int st;
        send(6'd14, 5'd0, 5'd12, 5'd13, 32'h1234, 32'h5555, st);
        checks++; if (bus.alu_control !== 4'd4 || bus.alu_oper2 !== 32'd0) begin errors++; $display("[TB] FAIL mov_issue ctrl=%0h op2=%0h exp ctrl=4 op2=0", bus.alu_control, bus.alu_oper2); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL mov_rd0 got=%0h exp=0", bus.wb_valid); end
        send(6'd14, 5'd4, 5'd12, 5'd13, 32'hDEAD, 32'h5555, st);
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd4 || bus.wb_data !== 32'hDEAD) begin errors++; $display("[TB] FAIL mov_wb rd=%0d data=%0h exp rd=4 data=dead", bus.wb_rd, bus.wb_data); end
    endtask

    task automatic test_reset_midflight();
        int st;
        send(6'd0, 5'd10, 5'd20, 5'd21, 32'd1, 32'd1, st);
        send(6'd0, 5'd11, 5'd22, 5'd23, 32'd2, 32'd2, st);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin errors++; $display("[TB] FAIL mid_wb v=%0h rd=%0d data=%0h exp all 0", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        checks++; if (bus.alu_control !== 4'd0 || bus.alu_oper1 !== 32'd0 || bus.alu_oper2 !== 32'd0) begin errors++; $display("[TB] FAIL mid_alu ctrl=%0h op1=%0h op2=%0h exp all 0", bus.alu_control, bus.alu_oper1, bus.alu_oper2); end
        checks++; if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL mid_flags br=%0h tk=%0h err=%0h exp all 0", bus.br_valid, bus.br_taken, bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%0h exp=1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_dropped cycle=%0d got=%0h exp=0", i, bus.wb_valid); end
            @(negedge clk);
        end
    endtask

    // Run every scenario in order and report the totals
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 6'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs     = 5'd0;
        bus.in_rt     = 5'd0;
        bus.in_rs_val = 32'd0;
        bus.in_rt_val = 32'd0;
        test_reset();
        test_add();
        test_mul_beq();
        test_back_to_back();
        test_hazard();
        test_illegal();
        test_mov();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a run that never reaches the summary
    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
